// File: rtl/axil_native_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axil_native_pkg
// Description : Shared constants and FSM encoding for the AXI4-Lite bridge
//               to the FF test core native register bus.
// Revision    : 1.0
// ============================================================================
package axil_native_pkg;

    localparam logic [1:0]  RESP_OKAY             = 2'b00;
    localparam logic [1:0]  RESP_SLVERR           = 2'b10;
    localparam logic [1:0]  RESP_DECERR           = 2'b11;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_WAIT     = 3'd3,
        ST_WR_RESP  = 3'd4,
        ST_RD_RESP  = 3'd5
    } state_t;

endpackage : axil_native_pkg
`default_nettype wire

// File: rtl/axil_native_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axil_native_bridge
// Description : AXI4-Lite slave issuing single-beat native register accesses,
//               one outstanding, with fair read/write arbitration and timeout.
// Revision    : 1.0
// ============================================================================
module axil_native_bridge
    import axil_native_pkg::*;
#(
    parameter int          NATIVE_ADDR_WDITH = 3,
    parameter int          NATIVE_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH    = 8,
    parameter int          TIMEOUT           = 255,
    parameter logic [31:0] TIMEOUT_RDATA     = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                         NATIVE_CLK,
    input  logic                         rst_n,

    input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,

    output logic                         NATIVE_EN,
    output logic                         NATIVE_WR,
    output logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
    input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    input  logic                         NATIVE_READY
);

    // Last wait cycle: the wait window spans exactly TIMEOUT cycles.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t                         r_state;
    state_t                         w_next_state;

    logic                           r_live;
    logic                           r_prio_rd;
    logic                           r_wr;
    logic [NATIVE_ADDR_WDITH-1:0]   r_addr;
    logic [NATIVE_DATA_WIDTH-1:0]   r_wdata;
    logic [31:0]                    r_rdata;
    logic [1:0]                     r_resp;
    logic [7:0]                     r_cnt;

    logic                           w_wr_elig;
    logic                           w_rd_elig;
    logic                           w_take_wr;
    logic                           w_take_rd;
    logic                           w_accept;
    logic                           w_aw_decerr;
    logic                           w_ar_decerr;
    logic                           w_strb_err;
    logic [1:0]                     w_acc_resp;
    logic                           w_acc_err;
    logic [NATIVE_ADDR_WDITH-1:0]   w_addr_sel;
    logic                           w_timeout;
    logic                           w_wait_done;

    // r_live keeps the combinational handshakes low while reset is asserted.
    assign w_wr_elig   = r_live && (r_state == ST_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_elig   = r_live && (r_state == ST_IDLE) && s_axi_arvalid;
    assign w_take_wr   = w_wr_elig && (!w_rd_elig || !r_prio_rd);
    assign w_take_rd   = w_rd_elig && !w_take_wr;
    assign w_accept    = w_take_wr || w_take_rd;

    assign w_aw_decerr = |(s_axi_awaddr >> (NATIVE_ADDR_WDITH + 2));
    assign w_ar_decerr = |(s_axi_araddr >> (NATIVE_ADDR_WDITH + 2));
    assign w_strb_err  = (s_axi_wstrb != 4'hF);

    always_comb begin
        w_acc_resp = RESP_OKAY;
        if (w_take_wr) begin
            if (w_aw_decerr)
                w_acc_resp = RESP_DECERR;
            else if (w_strb_err)
                w_acc_resp = RESP_SLVERR;
        end else if (w_ar_decerr) begin
            w_acc_resp = RESP_DECERR;
        end
    end

    assign w_acc_err   = (w_acc_resp != RESP_OKAY);
    assign w_addr_sel  = w_take_wr ? s_axi_awaddr[NATIVE_ADDR_WDITH+1:2]
                                   : s_axi_araddr[NATIVE_ADDR_WDITH+1:2];
    assign w_timeout   = (r_cnt == c_cnt_last);
    assign w_wait_done = (r_state == ST_WAIT) && (NATIVE_READY || w_timeout);

    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_wr)
                    w_next_state = w_acc_err ? ST_WR_RESP : ST_WR_ISSUE;
                else if (w_take_rd)
                    w_next_state = w_acc_err ? ST_RD_RESP : ST_RD_ISSUE;
            end
            ST_WR_ISSUE,
            ST_RD_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_wait_done)
                    w_next_state = r_wr ? ST_WR_RESP : ST_RD_RESP;
            end
            ST_WR_RESP: begin
                if (s_axi_bready)
                    w_next_state = ST_IDLE;
            end
            ST_RD_RESP: begin
                if (s_axi_rready)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = w_take_wr;
        s_axi_wready  = w_take_wr;
        s_axi_arready = w_take_rd;
        NATIVE_EN     = (r_state == ST_WR_ISSUE) || (r_state == ST_RD_ISSUE);
        s_axi_bvalid  = (r_state == ST_WR_RESP);
        s_axi_rvalid  = (r_state == ST_RD_RESP);
    end

    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_prio_rd <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
            r_cnt     <= '0;
        end else begin
            r_live <= 1'b1;

            if (w_accept) begin
                r_prio_rd <= ~r_prio_rd;
                r_wr      <= w_take_wr;
                r_addr    <= w_addr_sel;
                r_resp    <= w_acc_resp;
                if (w_take_wr)
                    r_wdata <= s_axi_wdata;
                if (w_take_rd && w_acc_err)
                    r_rdata <= TIMEOUT_RDATA;
            end

            if (r_state == ST_WAIT)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;

            // A READY on the final wait cycle still wins over the timeout.
            if (r_state == ST_WAIT) begin
                if (NATIVE_READY) begin
                    r_resp <= RESP_OKAY;
                    if (!r_wr)
                        r_rdata <= NATIVE_DATA_OUT;
                end else if (w_timeout) begin
                    r_resp <= RESP_SLVERR;
                    if (!r_wr)
                        r_rdata <= TIMEOUT_RDATA;
                end
            end
        end
    end

    assign NATIVE_WR      = r_wr;
    assign NATIVE_ADDR    = r_addr;
    assign NATIVE_DATA_IN = r_wdata;
    assign s_axi_bresp    = r_resp;
    assign s_axi_rresp    = r_resp;
    assign s_axi_rdata    = r_rdata;

endmodule : axil_native_bridge
`default_nettype wire
